// File: rtl/icap_pr_controller_if.sv
// Stream, ICAP and status signals of the partial-reconfiguration controller.
// The slave view belongs to the controller; the master view belongs to its environment.
interface icap_pr_controller_if;
   logic        xStart;
   logic        xAbort;
   logic [63:0] xS_AXIS_tdata;
   logic [7:0]  xS_AXIS_tkeep;
   logic        xS_AXIS_tlast;
   logic        xS_AXIS_tvalid;
   logic        xS_AXIS_tready;
   logic        xIcapCsib;
   logic        xIcapRdwrb;
   logic [31:0] xIcapI;
   logic        xIcapAvail;
   logic        xIcapPrDone;
   logic        xIcapPrError;
   logic        xBusy;
   logic        xDone;
   logic        xError;
   logic [1:0]  xErrCode;
   logic [31:0] xWordCount;

   modport slave (
      input  xStart, xAbort,
      input  xS_AXIS_tdata, xS_AXIS_tkeep, xS_AXIS_tlast, xS_AXIS_tvalid,
      output xS_AXIS_tready,
      output xIcapCsib, xIcapRdwrb, xIcapI,
      input  xIcapAvail, xIcapPrDone, xIcapPrError,
      output xBusy, xDone, xError, xErrCode, xWordCount
   );

   modport master (
      output xStart, xAbort,
      output xS_AXIS_tdata, xS_AXIS_tkeep, xS_AXIS_tlast, xS_AXIS_tvalid,
      input  xS_AXIS_tready,
      input  xIcapCsib, xIcapRdwrb, xIcapI,
      output xIcapAvail, xIcapPrDone, xIcapPrError,
      input  xBusy, xDone, xError, xErrCode, xWordCount
   );
endinterface

// File: rtl/icap_pr_controller.sv
// ICAPE3 partial-reconfiguration sequencer: splits 64-bit stream beats into
// two 32-bit ICAP writes, then tracks PRDONE/PRERROR and a stall timeout.
module icap_pr_controller #(
   parameter int BIT_SWAP       = 1,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input logic AxiBusClock,
   input logic xAxiBusReset,
   icap_pr_controller_if.slave bus
);

   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE, ARMED, WR_LO, WR_HI, WAIT_DONE, DONE, ERROR
   } stateT;

   stateT       state;
   stateT       nextState;
   logic [TW-1:0] timer;
   logic [31:0] icapWord;
   logic [31:0] hiWord;
   logic        hiPending;
   logic        lastHold;
   logic        busyReg;
   logic        doneReg;
   logic        errorReg;
   logic [1:0]  errCodeReg;
   logic [31:0] wordCount;

   logic        busyState;
   logic        timedState;
   logic        keepBad;
   logic        writeNow;
   logic        acceptBeat;
   logic [1:0]  errCodeNext;
   logic [3:0]  loKeep;
   logic [3:0]  hiKeep;

   // Reverses the bit order inside each byte when BIT_SWAP is set.
   function automatic logic [31:0] swapWord(input logic [31:0] w);
      logic [31:0] r;
      r = w;
      if (BIT_SWAP != 0) begin
         for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 8; k++) begin
               r[8*b + k] = w[8*b + 7 - k];
            end
         end
      end
      return r;
   endfunction

   assign loKeep     = bus.xS_AXIS_tkeep[3:0];
   assign hiKeep     = bus.xS_AXIS_tkeep[7:4];
   assign keepBad    = !(loKeep inside {4'h0, 4'hF}) || !(hiKeep inside {4'h0, 4'hF});
   assign busyState  = state inside {ARMED, WR_LO, WR_HI, WAIT_DONE};
   assign timedState = state inside {WR_LO, WR_HI, WAIT_DONE};

   // Next-state decision in priority order: abort, PRERROR, timeout, then normal flow.
   always_comb begin
      nextState   = state;
      writeNow    = 1'b0;
      acceptBeat  = 1'b0;
      errCodeNext = 2'b00;
      if (bus.xAbort) begin
         nextState = IDLE;
      end else if (busyState && bus.xIcapPrError) begin
         nextState   = ERROR;
         errCodeNext = 2'b01;
      end else if (timedState && (timer == TIMER_MAX)) begin
         nextState   = ERROR;
         errCodeNext = 2'b10;
      end else begin
         case (state)
            IDLE, DONE, ERROR: begin
               if (bus.xStart) nextState = ARMED;
            end
            ARMED: begin
               if (bus.xS_AXIS_tvalid) begin
                  if (keepBad) begin
                     nextState   = ERROR;
                     errCodeNext = 2'b11;
                  end else begin
                     acceptBeat = 1'b1;
                     if (loKeep == 4'hF)             nextState = WR_LO;
                     else if (hiKeep == 4'hF)        nextState = WR_HI;
                     else if (bus.xS_AXIS_tlast)     nextState = WAIT_DONE;
                  end
               end
            end
            WR_LO: begin
               if (bus.xIcapAvail) begin
                  writeNow = 1'b1;
                  if (hiPending)     nextState = WR_HI;
                  else if (lastHold) nextState = WAIT_DONE;
                  else               nextState = ARMED;
               end
            end
            WR_HI: begin
               if (bus.xIcapAvail) begin
                  writeNow  = 1'b1;
                  nextState = lastHold ? WAIT_DONE : ARMED;
               end
            end
            WAIT_DONE: begin
               if (bus.xIcapPrDone) nextState = DONE;
            end
            default: nextState = IDLE;
         endcase
      end
   end

   // State, holding registers, stall timer and registered status.
   always_ff @(posedge AxiBusClock or posedge xAxiBusReset) begin
      if (xAxiBusReset) begin
         state      <= IDLE;
         timer      <= '0;
         icapWord   <= '0;
         hiWord     <= '0;
         hiPending  <= 1'b0;
         lastHold   <= 1'b0;
         busyReg    <= 1'b0;
         doneReg    <= 1'b0;
         errorReg   <= 1'b0;
         errCodeReg <= 2'b00;
         wordCount  <= '0;
      end else begin
         state   <= nextState;
         busyReg <= nextState inside {ARMED, WR_LO, WR_HI, WAIT_DONE};

         if ((nextState != state) || !timedState) timer <= '0;
         else                                     timer <= timer + TW'(1);

         if (bus.xAbort) begin
            doneReg    <= 1'b0;
            errorReg   <= 1'b0;
            errCodeReg <= 2'b00;
         end else if (errCodeNext != 2'b00) begin
            errorReg   <= 1'b1;
            errCodeReg <= errCodeNext;
         end else if ((state == WAIT_DONE) && (nextState == DONE)) begin
            doneReg <= 1'b1;
         end else if (!busyState && (nextState == ARMED)) begin
            doneReg    <= 1'b0;
            errorReg   <= 1'b0;
            errCodeReg <= 2'b00;
            wordCount  <= '0;
         end

         if (writeNow) wordCount <= wordCount + 32'd1;

         // The first half to write goes straight to the ICAP data register on accept.
         if (acceptBeat) begin
            hiWord    <= bus.xS_AXIS_tdata[63:32];
            hiPending <= (loKeep == 4'hF) && (hiKeep == 4'hF);
            lastHold  <= bus.xS_AXIS_tlast;
            icapWord  <= (loKeep == 4'hF) ? swapWord(bus.xS_AXIS_tdata[31:0])
                                          : swapWord(bus.xS_AXIS_tdata[63:32]);
         end else if (writeNow && (state == WR_LO) && hiPending) begin
            icapWord <= swapWord(hiWord);
         end
      end
   end

   assign bus.xS_AXIS_tready = (state == ARMED);
   assign bus.xIcapCsib      = !(((state == WR_LO) || (state == WR_HI)) && bus.xIcapAvail);
   assign bus.xIcapRdwrb     = 1'b0;
   assign bus.xIcapI         = icapWord;
   assign bus.xBusy          = busyReg;
   assign bus.xDone          = doneReg;
   assign bus.xError         = errorReg;
   assign bus.xErrCode       = errCodeReg;
   assign bus.xWordCount     = wordCount;

endmodule

// File: doc/icap_pr_controller.md
# icap_pr_controller

Sequences the ICAPE3 configuration port for partial reconfiguration. It accepts the 64-bit AXI4-Stream bitstream from the PCIe bridge, splits each beat into two 32-bit ICAP writes (low word first) and applies optional per-byte bit reversal. It then monitors PRDONE/PRERROR and reports busy, done and error status to the MCU control register. It replaces the direct tready/CSIB wiring between the stream and the ICAP primitive.

## Interface
Parameters:
- BIT_SWAP, 1, 1 = reverse bit order within each byte of every ICAP word; 0 = pass through.
- TIMEOUT_CYCLES, 1048576, number of stalled cycles in WR_LO, WR_HI or WAIT_DONE that raises a timeout error; minimum 2.

Ports:
- AxiBusClock  in  1  sole clock.
- xAxiBusReset  in  1  asynchronous, active-high reset.
- xStart  in  1  single-cycle pulse that arms a transfer.
- xAbort  in  1  single-cycle pulse that cancels any transfer.
- xS_AXIS_tdata  in  64  bitstream beat.
- xS_AXIS_tkeep  in  8  byte enables.
- xS_AXIS_tlast  in  1  last beat of bitstream.
- xS_AXIS_tvalid  in  1  beat valid.
- xS_AXIS_tready  out  1  beat accepted.
- xIcapCsib  out  1  ICAP enable, active low.
- xIcapRdwrb  out  1  constant 0 (write).
- xIcapI  out  32  ICAP write data.
- xIcapAvail  in  1  ICAP AVAIL.
- xIcapPrDone  in  1  ICAP PRDONE.
- xIcapPrError  in  1  ICAP PRERROR.
- xBusy  out  1  transfer in progress (ARMED, WR_LO, WR_HI or WAIT_DONE).
- xDone  out  1  sticky completion flag.
- xError  out  1  sticky error flag.
- xErrCode  out  2  error cause: 00 none, 01 PRERROR, 10 timeout, 11 bad tkeep.
- xWordCount  out  32  ICAP words written since the last xStart; wraps at 2^32.

## Operation
States: IDLE, ARMED, WR_LO, WR_HI, WAIT_DONE, DONE, ERROR.
- **IDLE:** xStart goes to ARMED and clears xDone, xError, xErrCode and xWordCount.
- **DONE / ERROR:** behave like IDLE. xStart clears all status and goes to ARMED.
- **ARMED:** xS_AXIS_tready = 1 in this state only.
  - On tvalid, the beat, keep and last are captured into holding registers.
  - Each 32-bit half has its own keep nibble. A nibble of 4'hF means write that half; 4'h0 means skip it. Any other nibble value means ERROR with code 11, and nothing is written from that beat.
  - Next state is the first half to write: WR_LO, then WR_HI.
  - If no halves are to be written: go to WAIT_DONE when last = 1, otherwise stay in ARMED.
- **WR_LO / WR_HI:**
  - xIcapCsib = !xIcapAvail. This is combinational from the state register and AVAIL.
  - When AVAIL = 1 the word is written in that cycle, xWordCount increments, and the state advances to:
    - WR_HI, if that half is still pending;
    - otherwise WAIT_DONE, if last = 1;
    - otherwise ARMED.
  - When AVAIL = 0, the state holds and CSIB stays 1.
- **WAIT_DONE:** xIcapPrDone = 1 goes to DONE.
- **xIcapI:** the registered holding half, bit-swapped when BIT_SWAP = 1. Bits [7:0] become reverse([7:0]), and likewise for every other byte.
- **PRERROR:** xIcapPrError = 1 in any state in which xBusy = 1 goes to ERROR with code 01. It has priority over PRDONE in the same cycle.
- **Timeout:** the counter clears on every state transition and counts cycles spent in WR_LO, WR_HI and WAIT_DONE. Reaching TIMEOUT_CYCLES-1 goes to ERROR with code 10. ARMED is not timed.
- **xAbort:** highest priority. From any state, go to IDLE with CSIB = 1, tready = 0, xDone = 0, xError = 0, xErrCode = 00. xWordCount holds.
- **Priority:** xAbort > PRERROR > timeout > normal transitions. xStart is ignored while xBusy = 1.

## Timing
- **Reset values:**
  - state = IDLE, xS_AXIS_tready = 0, xIcapCsib = 1, xIcapRdwrb = 0, xIcapI = 0;
  - xBusy = 0, xDone = 0, xError = 0, xErrCode = 00, xWordCount = 0.
- **Start:** xStart in cycle N gives tready = 1 in cycle N+1.
- **Data path, with AVAIL held at 1:**
  - A beat accepted in cycle N has its low word on xIcapI with CSIB = 0 in cycle N+1.
  - The high word follows in cycle N+2.
  - tready is high again in cycle N+3.
  - Throughput is one full beat per 3 cycles.
- **Skipped halves:** a skipped low half moves the high-word write to cycle N+1.
- **Stall:** CSIB follows AVAIL with zero latency. xIcapI is stable for the whole stall.
- **Completion:** PRDONE in cycle M gives xDone = 1 and xBusy = 0 in cycle M+1.
- **Status changes:** all status outputs are registered and change one cycle after the causing event.
- **Reset mid-transfer:** asynchronous reset immediately forces CSIB = 1 and tready = 0.

## Test plan
- **Two-beat transfer:** xStart, beats 64'h11223344_AABBCCDD and 64'h55667788_99000011, both keep FF, last on the second beat, BIT_SWAP = 0, AVAIL = 1. Required: ICAP writes AABBCCDD, 11223344, 99000011, 55667788 on consecutive CSIB-low cycles at the 3-cycle beat cadence; xWordCount = 4; PRDONE pulse gives xDone = 1, xBusy = 0.
- **Bit swap:** BIT_SWAP = 1, one beat 64'h0000000_00000001 with keep 0F and last. Required: a single write of 32'h00000080; no high-word write; xWordCount = 1.
- **AVAIL stall:** AVAIL held at 0 for 5 cycles inside WR_HI. Required: CSIB = 1 for those 5 cycles, data stable, write occurs in the first cycle AVAIL = 1; TIMEOUT_CYCLES = 4 instead gives xErrCode = 10.
- **Bad keep:** a beat with keep 8'h3F. Required: ERROR with code 11, zero ICAP writes, tready = 0 afterwards; a following xStart returns to ARMED with status cleared.
- **Error and abort priority:** PRERROR and PRDONE in the same WAIT_DONE cycle give xErrCode = 01 and xDone = 0. xAbort in WR_LO gives IDLE with CSIB = 1 and no write in the next cycle.
- **Reset mid-transfer:** xAxiBusReset asserted mid-beat gives all outputs at reset values within the same cycle.
